// File: rtl/thread_issue_scheduler.sv
// Round-robin issue scheduler across hardware threads.
// A thread that has waited too long while ready takes absolute priority.
module thread_issue_scheduler #(
  parameter int NUM_THREADS      = 8,
  parameter int STARVATION_LIMIT = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_THREADS-1:0]         ib_instructions_valid,
  input  logic [NUM_THREADS-1:0]         hz_can_issue,
  input  logic [NUM_THREADS-1:0]         thread_en,
  input  logic [NUM_THREADS-1:0]         rb_valid,
  output logic [NUM_THREADS-1:0]         is_thread_scheduled_mask,
  output logic                           is_instr_valid,
  output logic [$clog2(NUM_THREADS)-1:0] is_thread_id
);

  localparam int TW = $clog2(NUM_THREADS);
  localparam int CW = $clog2(STARVATION_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVATION_LIMIT);

  logic [TW-1:0]          r_last_ptr;
  logic [CW-1:0]          r_wcnt [NUM_THREADS];
  logic                   r_iv;
  logic [TW-1:0]          r_id;

  logic [NUM_THREADS-1:0] w_elig;
  logic [NUM_THREADS-1:0] w_wait;
  logic                   w_starv_any;
  logic [TW-1:0]          w_starv_id;
  logic                   w_rr_any;
  logic [TW-1:0]          w_rr_id;
  logic                   w_gv;
  logic [TW-1:0]          w_gid;
  logic [NUM_THREADS-1:0] w_mask;

  always_comb begin
    w_elig = ib_instructions_valid & hz_can_issue
           & thread_en & ~rb_valid;
    w_wait = ib_instructions_valid & thread_en & ~rb_valid;
    w_starv_any = 1'b0;
    w_starv_id  = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (r_wcnt[i] == LIM && w_elig[i]) begin
        w_starv_any = 1'b1;
        w_starv_id  = TW'(i);
      end
    end
    // Scan downward so the nearest candidate after last_ptr wins.
    w_rr_any = 1'b0;
    w_rr_id  = '0;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      if (w_elig[r_last_ptr + TW'(k)]) begin
        w_rr_any = 1'b1;
        w_rr_id  = r_last_ptr + TW'(k);
      end
    end
    w_gv   = enable & reset & (w_starv_any | w_rr_any);
    w_gid  = w_starv_any ? w_starv_id : w_rr_id;
    w_mask = w_gv ? (NUM_THREADS'(1) << w_gid) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_ptr <= TW'(NUM_THREADS - 1);
      r_iv       <= 1'b0;
      r_id       <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_wcnt[i] <= '0;
      end
    end else begin
      r_iv <= w_gv;
      if (w_gv) begin
        r_id       <= w_gid;
        r_last_ptr <= w_gid;
      end
      if (enable) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
          if (!w_wait[i] || (w_gv && w_gid == TW'(i))) begin
            r_wcnt[i] <= '0;
          end else if (r_wcnt[i] != LIM) begin
            r_wcnt[i] <= r_wcnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign is_thread_scheduled_mask = w_mask;
  assign is_instr_valid           = r_iv;
  assign is_thread_id             = r_id;

endmodule

// File: tb/tb_thread_issue_scheduler.sv
// Scoreboard bench for thread_issue_scheduler.
// Directed scenarios plus a constrained-random run.
module tb_thread_issue_scheduler;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] iv_in;
  logic [7:0] hz;
  logic [7:0] ten;
  logic [7:0] rb;
  logic [7:0] mask;
  logic       o_iv;
  logic [2:0] o_id;

  int n_vec;
  int n_err;

  int         m_ptr;
  int         m_wcnt [8];
  logic       m_gv;
  int         m_gid;
  logic [2:0] m_id;
  logic [7:0] e_mask;
  logic       e_iv;
  logic [2:0] e_id;
  logic [3:0] sb_q [$];

  thread_issue_scheduler #(
    .NUM_THREADS(8),
    .STARVATION_LIMIT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .ib_instructions_valid(iv_in),
    .hz_can_issue(hz),
    .thread_en(ten),
    .rb_valid(rb),
    .is_thread_scheduled_mask(mask),
    .is_instr_valid(o_iv),
    .is_thread_id(o_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_ptr = 7;
    m_id  = 3'd0;
    for (int i = 0; i < 8; i++) m_wcnt[i] = 0;
    sb_q.delete();
  endtask

  task automatic model_eval();
    logic [7:0] el;
    el    = iv_in & hz & ten & ~rb;
    m_gv  = 1'b0;
    m_gid = 0;
    if (enable && reset) begin
      for (int i = 0; i < 8; i++)
        if (!m_gv && m_wcnt[i] == 15 && el[i]) begin
          m_gv  = 1'b1;
          m_gid = i;
        end
      for (int k = 1; k <= 8; k++) begin
        int j;
        j = (m_ptr + k) % 8;
        if (!m_gv && el[j]) begin
          m_gv  = 1'b1;
          m_gid = j;
        end
      end
    end
  endtask

  task automatic model_commit();
    logic [7:0] w;
    w = iv_in & ten & ~rb;
    if (enable && reset) begin
      for (int i = 0; i < 8; i++) begin
        if (!w[i] || (m_gv && m_gid == i)) m_wcnt[i] = 0;
        else if (m_wcnt[i] < 15) m_wcnt[i] = m_wcnt[i] + 1;
      end
      if (m_gv) begin
        m_ptr = m_gid;
        m_id  = 3'(m_gid);
      end
    end
  endtask

  // Inputs are expected to be stable since posedge+1.
  task automatic pre();
    #2;
    model_eval();
    e_mask = m_gv ? (8'd1 << m_gid) : 8'd0;
    sb_q.push_back({m_gv, m_gv ? 3'(m_gid) : m_id});
  endtask

  task automatic post();
    model_commit();
    @(posedge clk);
    #1;
    {e_iv, e_id} = sb_q.pop_front();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b1;
    iv_in  = 8'hFF;
    hz     = 8'hFF;
    ten    = 8'hFF;
    rb     = 8'h00;
    model_reset();
    #1;
    n_vec++;
    if (mask !== 8'h00 || o_iv !== 1'b0 || o_id !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: mask=%h iv=%b id=%0d, want 00 0 0",
               mask, o_iv, o_id);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    n_vec++;
    if (mask !== 8'h00 || o_iv !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: mask=%h iv=%b, want 00 0", mask, o_iv);
    end
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 9; c++) begin
      iv_in = 8'hFF; hz = 8'hFF; ten = 8'hFF; rb = 8'h00; enable = 1'b1;
      pre();
      n_vec++;
      if (mask !== e_mask || mask !== (8'd1 << (c % 8))) begin
        n_err++;
        $display("FAIL rr_mask[%0d]: got %h, want %h", c, mask, e_mask);
      end
      post();
      n_vec++;
      if ({o_iv, o_id} !== {e_iv, e_id} || o_id !== 3'(c % 8)) begin
        n_err++;
        $display("FAIL rr_id[%0d]: got %b/%0d, want %b/%0d",
                 c, o_iv, o_id, e_iv, e_id);
      end
    end
  endtask

  task automatic test_two_threads();
    logic [7:0] exp_m;
    iv_in = 8'h20; hz = 8'hFF; ten = 8'hFF; rb = 8'h00; enable = 1'b1;
    pre();
    post();
    for (int c = 0; c < 4; c++) begin
      iv_in = 8'h24;
      exp_m = (c % 2 == 0) ? 8'h04 : 8'h20;
      pre();
      n_vec++;
      if (mask !== e_mask || mask !== exp_m) begin
        n_err++;
        $display("FAIL two_mask[%0d]: got %h, want %h", c, mask, exp_m);
      end
      post();
      n_vec++;
      if ({o_iv, o_id} !== {e_iv, e_id}) begin
        n_err++;
        $display("FAIL two_id[%0d]: got %b/%0d, want %b/%0d",
                 c, o_iv, o_id, e_iv, e_id);
      end
    end
  endtask

  task automatic test_starvation();
    int extra;
    iv_in = 8'hFF; hz = 8'hF7; ten = 8'hFF; rb = 8'h00; enable = 1'b1;
    extra = 0;
    for (int c = 0; c < 21; c++) begin
      if (c == 20 && m_ptr != 2) break;
      pre();
      n_vec++;
      if (mask !== e_mask) begin
        n_err++;
        $display("FAIL hz_mask[%0d]: got %h, want %h", c, mask, e_mask);
      end
      post();
    end
    n_vec++;
    if (dut.r_wcnt[3] !== 4'd15) begin
      n_err++;
      $display("FAIL starve_sat: wcnt3=%0d, want 15", dut.r_wcnt[3]);
    end
    hz = 8'hFF;
    pre();
    n_vec++;
    if (mask !== 8'h08 || mask !== e_mask) begin
      n_err++;
      $display("FAIL starve_grant: got %h, want 08", mask);
    end
    post();
    n_vec++;
    if (o_id !== 3'd3 || o_iv !== 1'b1 || dut.r_wcnt[3] !== 4'd0) begin
      n_err++;
      $display("FAIL starve_after: id=%0d iv=%b wcnt3=%0d, want 3 1 0",
               o_id, o_iv, dut.r_wcnt[3]);
    end
  endtask

  task automatic test_rollback();
    iv_in = 8'hFF; hz = 8'h01; ten = 8'hFF; rb = 8'h00; enable = 1'b1;
    pre();
    post();
    hz = 8'hFF;
    rb = 8'h02;
    pre();
    n_vec++;
    if (mask !== 8'h04 || mask !== e_mask) begin
      n_err++;
      $display("FAIL rb_mask: got %h, want 04", mask);
    end
    post();
    n_vec++;
    if (dut.r_wcnt[1] !== 4'd0 || o_id !== 3'd2) begin
      n_err++;
      $display("FAIL rb_clear: wcnt1=%0d id=%0d, want 0 2",
               dut.r_wcnt[1], o_id);
    end
    rb = 8'h00;
  endtask

  task automatic test_enable();
    iv_in = 8'hFF; hz = 8'h10; ten = 8'hFF; rb = 8'h00; enable = 1'b1;
    pre();
    post();
    hz = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      enable = 1'b0;
      pre();
      n_vec++;
      if (mask !== 8'h00) begin
        n_err++;
        $display("FAIL en_mask[%0d]: got %h, want 00", c, mask);
      end
      post();
      n_vec++;
      if (o_iv !== 1'b0 || {o_iv, o_id} !== {e_iv, e_id}) begin
        n_err++;
        $display("FAIL en_iv[%0d]: got %b/%0d, want %b/%0d",
                 c, o_iv, o_id, e_iv, e_id);
      end
    end
    enable = 1'b1;
    pre();
    n_vec++;
    if (mask !== 8'h20 || mask !== e_mask) begin
      n_err++;
      $display("FAIL en_resume: got %h, want 20", mask);
    end
    post();
  endtask

  task automatic test_reset_mid();
    iv_in = 8'hFF; hz = 8'hFF; ten = 8'hFF; rb = 8'h00; enable = 1'b1;
    pre();
    post();
    n_vec++;
    if (o_iv !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre: iv=%b, want 1", o_iv);
    end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (o_iv !== 1'b0 || o_id !== 3'd0 || mask !== 8'h00) begin
      n_err++;
      $display("FAIL mid_async: iv=%b id=%0d mask=%h, want 0 0 00",
               o_iv, o_id, mask);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    pre();
    n_vec++;
    if (mask !== 8'h01 || mask !== e_mask) begin
      n_err++;
      $display("FAIL mid_first: got %h, want 01", mask);
    end
    post();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      iv_in  = 8'($urandom);
      hz     = 8'($urandom) | 8'($urandom);
      ten    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
      rb     = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      enable = ($urandom_range(0, 7) != 0);
      pre();
      n_vec++;
      if (mask !== e_mask || (mask & (rb | ~iv_in)) !== 8'h00) begin
        n_err++;
        $display("FAIL rnd_mask[%0d]: got %h, want %h", c, mask, e_mask);
      end
      post();
      n_vec++;
      if ({o_iv, o_id} !== {e_iv, e_id}) begin
        n_err++;
        $display("FAIL rnd_id[%0d]: got %b/%0d, want %b/%0d",
                 c, o_iv, o_id, e_iv, e_id);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_round_robin();
    test_two_threads();
    test_starvation();
    test_rollback();
    test_enable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
